// File: rtl/i2c_seq_pkg.sv
// Shared types and defaults for the I2C write sequencer.
package i2c_seq_pkg;

  localparam int LEN_W_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 20000;
  localparam int TO_W_DEF        = 15;

  // R/W bit appended to the 7-bit slave address; this block only writes.
  localparam logic ADDR_WR_BIT = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_MRDY,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_HOLD,
    S_LOAD,
    S_WAIT_TXD,
    S_WAIT_ACK,
    S_FETCH,
    S_STOP,
    S_WAIT_SBUSY,
    S_WAIT_IDLE,
    S_DONE
  } seq_state_e;

  // States in which the sequencer waits on the master and the watchdog runs.
  function automatic logic is_wait_state(input seq_state_e s);
    return s inside {S_WAIT_MRDY, S_WAIT_BUSY, S_WAIT_HOLD, S_WAIT_TXD,
                     S_WAIT_ACK, S_WAIT_SBUSY, S_WAIT_IDLE};
  endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Per-state watchdog: counts cycles while enabled, restarts on every state
// change, and flags expiry once TIMEOUT_CYC cycles have been spent.
module i2c_seq_watchdog #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int TO_W        = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  // Cycle counter; saturates at LAST so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/i2c_write_sequencer.sv
// Write-transaction controller in front of the I2C byte master.
//
// Handshakes: a command is taken on the cycle cmd_valid & cmd_ready are both
// high; a payload byte is taken on the cycle wr_valid & wr_ready are both high.
// The upstream source must hold wr_valid/wr_data stable until that cycle.
// wr_ready is a registered one-cycle pulse raised only in S_FETCH, the cycle
// after wr_valid is seen, so there is no input-to-output combinational path.
module i2c_write_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_i2c_en,
  output logic [7:0]       m_tx_data,
  input  logic             m_ready,
  input  logic             m_tx_done,
  output seq_state_e       dbg_state
);

  seq_state_e       state;
  seq_state_e       state_next;
  logic [7:0]       byte_reg;
  logic [LEN_W-1:0] remaining;
  logic             err_flag;
  logic             wr_ready_q;
  logic             wd_expire;

  i2c_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (is_wait_state(state)),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: byte register, remaining count, error flag and pop strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_reg   <= 8'hFF;
      remaining  <= '0;
      err_flag   <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            byte_reg  <= {cmd_addr, ADDR_WR_BIT};
            remaining <= cmd_len;
          end
        end
        S_FETCH: begin
          if (!wr_ready_q && wr_valid) begin
            wr_ready_q <= 1'b1;
          end
          if (wr_ready_q && wr_valid) begin
            byte_reg <= wr_data;
            if (remaining != '0) begin
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        S_DONE: err_flag <= 1'b0;
        default: ;
      endcase
      if (wd_expire) begin
        err_flag <= 1'b1;
      end
    end
  end

  // Next-state logic; a watchdog expiry overrides the normal wait exit.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (cmd_valid) state_next = S_WAIT_MRDY;
      S_WAIT_MRDY:  if (wd_expire) state_next = S_STOP;
                    else if (m_ready) state_next = S_START;
      S_START:      state_next = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (wd_expire) state_next = S_STOP;
                    else if (!m_ready) state_next = S_WAIT_HOLD;
      S_WAIT_HOLD:  if (wd_expire) state_next = S_STOP;
                    else if (m_ready) state_next = S_LOAD;
      S_LOAD:       state_next = S_WAIT_TXD;
      S_WAIT_TXD:   if (wd_expire) state_next = S_STOP;
                    else if (m_tx_done) state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (wd_expire) state_next = S_STOP;
        else if (m_ready) state_next = (remaining == '0) ? S_STOP : S_FETCH;
      end
      S_FETCH:      if (wr_ready_q && wr_valid) state_next = S_LOAD;
      S_STOP:       state_next = S_WAIT_SBUSY;
      S_WAIT_SBUSY: if (wd_expire) state_next = S_DONE;
                    else if (!m_ready) state_next = S_WAIT_IDLE;
      S_WAIT_IDLE:  if (wd_expire) state_next = S_DONE;
                    else if (m_ready) state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    m_start   = 1'b0;
    m_stop    = 1'b0;
    m_i2c_en  = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_DONE: begin
        done = 1'b1;
        err  = err_flag;
      end
      S_START: begin
        busy     = 1'b1;
        m_start  = 1'b1;
        m_i2c_en = 1'b1;
      end
      S_LOAD: begin
        busy     = 1'b1;
        m_i2c_en = 1'b1;
      end
      S_STOP: begin
        busy     = 1'b1;
        m_stop   = 1'b1;
        m_i2c_en = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  assign m_tx_data = byte_reg;
  assign wr_ready  = wr_ready_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer with a fast behavioural I2C master stub.
module tb_i2c_write_sequencer;
  import i2c_seq_pkg::*;

  localparam int BIT = 8;     // stub master cycles per bit
  localparam int TO  = 300;   // watchdog limit used on the DUT
  localparam int TOW = 9;
  localparam int LW  = 4;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [6:0]    cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready, busy, done, err;
  logic          m_start, m_stop, m_i2c_en;
  logic [7:0]    m_tx_data;
  logic          m_ready;
  logic          m_tx_done;
  seq_state_e    dbg_state;

  always #5 clk = ~clk;

  i2c_write_sequencer #(.LEN_W(LW), .TIMEOUT_CYC(TO), .TO_W(TOW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
    .m_start(m_start), .m_stop(m_stop), .m_i2c_en(m_i2c_en), .m_tx_data(m_tx_data),
    .m_ready(m_ready), .m_tx_done(m_tx_done), .dbg_state(dbg_state)
  );

  // ---------------- master stub ----------------
  localparam logic [2:0] MS_IDLE = 3'd0, MS_START = 3'd1, MS_HOLD = 3'd2,
                         MS_DATA = 3'd3, MS_ACK = 3'd4, MS_STOP = 3'd5, MS_HANG = 3'd6;
  logic [2:0] ms;
  int         mcnt;
  bit         hang_mode = 1'b0;

  assign m_ready = (ms == MS_IDLE) || (ms == MS_HOLD);

  // Behavioural master: start, HOLD, 8 data bits + ack, stop; optional hang.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms <= MS_IDLE; mcnt <= 0; m_tx_done <= 1'b0;
    end else begin
      m_tx_done <= 1'b0;
      case (ms)
        MS_IDLE:  if (m_start && m_i2c_en) begin ms <= hang_mode ? MS_HANG : MS_START; mcnt <= 0; end
        MS_START: if (mcnt == BIT-1) ms <= MS_HOLD; else mcnt <= mcnt + 1;
        MS_HOLD: begin
          if (m_i2c_en && m_stop) begin ms <= MS_STOP; mcnt <= 0; end
          else if (m_i2c_en && !m_start) begin ms <= MS_DATA; mcnt <= 0; end
        end
        MS_DATA:  if (mcnt == 8*BIT-1) begin m_tx_done <= 1'b1; ms <= MS_ACK; mcnt <= 0; end
                  else mcnt <= mcnt + 1;
        MS_ACK:   if (mcnt == BIT-1) ms <= MS_HOLD; else mcnt <= mcnt + 1;
        MS_STOP:  if (mcnt == BIT-1) ms <= MS_IDLE; else mcnt <= mcnt + 1;
        MS_HANG:  if (!hang_mode) ms <= MS_IDLE;
        default:  ms <= MS_IDLE;
      endcase
    end
  end

  // ---------------- monitor (bus bytes and pulse counts) ----------------
  logic [7:0] got_mem[256];
  int got_wr = 0, start_cnt = 0, stop_cnt = 0, wrr_cnt = 0, en_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (m_i2c_en) en_cnt++;
      if (m_i2c_en && m_start) start_cnt++;
      if (m_i2c_en && m_stop) stop_cnt++;
      if (m_i2c_en && !m_start && !m_stop) begin
        got_mem[got_wr[7:0]] = m_tx_data;
        got_wr++;
      end
      if (wr_ready) wrr_cnt++;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         got_rd = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] feed_mem[16];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; hang_mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic [LW-1:0] l, output bit ok);
    ok = 1'b0;
    exp_q.push_back({a, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Presents feed_mem[0..n-1]; optionally stalls before byte stall_idx.
  task automatic feed(input int n, input int stall_idx, input int stall_cyc);
    bit seen;
    int e0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        for (int k = 0; k < 2000 && dbg_state != S_FETCH; k++) @(negedge clk);
        e0 = en_cnt;
        repeat (stall_cyc) @(negedge clk);
        checks++;
        if (en_cnt !== e0) begin
          errors++; $display("FAIL stall_en: m_i2c_en pulses during stall=%0d required=0", en_cnt - e0);
        end
        checks++;
        if (dbg_state !== S_FETCH || m_ready !== 1'b1) begin
          errors++; $display("FAIL stall_park: state=%0d m_ready=%b required state=%0d m_ready=1",
                             dbg_state, m_ready, S_FETCH);
        end
      end
      wr_valid = 1'b1; wr_data = feed_mem[i];
      seen = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if (wr_ready === 1'b1) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL feed_handshake: byte %0d wr_ready seen=0 required=1", i);
      end
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit got, output logic e, output int cyc);
    got = 1'b0; e = 1'b0; cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1'b1; e = err; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: rdy/busy/done/err=%b%b%b%b required=1000",
                         cmd_ready, busy, done, err);
    end
    checks++;
    if (m_start !== 1'b0 || m_stop !== 1'b0 || m_i2c_en !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_master: start/stop/en/wrr=%b%b%b%b required=0000",
                         m_start, m_stop, m_i2c_en, wr_ready);
    end
    checks++;
    if (m_tx_data !== 8'hFF) begin
      errors++; $display("FAIL reset_txdata: got=%h required=ff", m_tx_data);
    end
  endtask

  task automatic test_addr_only();
    bit ok, got; logic e; int cyc;
    int s0 = start_cnt, p0 = stop_cnt, w0 = wrr_cnt, g0 = got_wr;
    send_cmd(7'h3C, 4'd0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL addr_only_accept: accepted=0 required=1"); end
    wait_done(2000, got, e, cyc);
    checks++;
    if (!got) begin errors++; $display("FAIL addr_only_done: done seen=0 required=1"); end
    checks++;
    if (e !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL addr_only_err_busy: err=%b busy=%b required 0 0", e, busy);
    end
    checks++;
    if (start_cnt - s0 !== 1 || got_wr - g0 !== 1 || stop_cnt - p0 !== 1) begin
      errors++; $display("FAIL addr_only_pulses: start/load/stop=%0d/%0d/%0d required=1/1/1",
                         start_cnt - s0, got_wr - g0, stop_cnt - p0);
    end
    checks++;
    if (wrr_cnt - w0 !== 0) begin
      errors++; $display("FAIL addr_only_wrr: got=%0d required=0", wrr_cnt - w0);
    end
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL addr_only_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL addr_only_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  task automatic test_multi_byte();
    bit ok, got; logic e; int cyc;
    int w0 = wrr_cnt;
    feed_mem[0] = 8'hA5; feed_mem[1] = 8'h5A; feed_mem[2] = 8'hFF;
    send_cmd(7'h50, 4'd3, ok);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'hFF);
    fork
      feed(3, -1, 0);
      wait_done(3000, got, e, cyc);
    join
    checks++;
    if (!ok || !got || e !== 1'b0) begin
      errors++; $display("FAIL multi_done: accept=%b done=%b err=%b required 1 1 0", ok, got, e);
    end
    checks++;
    if (wrr_cnt - w0 !== 3) begin
      errors++; $display("FAIL multi_wrr: got=%0d required=3", wrr_cnt - w0);
    end
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL multi_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL multi_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  task automatic test_stall();
    bit ok, got; logic e; int cyc;
    feed_mem[0] = 8'hC3; feed_mem[1] = 8'h3C;
    send_cmd(7'h61, 4'd2, ok);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    fork
      feed(2, 1, TO + 50);
      wait_done(4000, got, e, cyc);
    join
    checks++;
    if (!ok || !got || e !== 1'b0) begin
      errors++; $display("FAIL stall_done: accept=%b done=%b err=%b required 1 1 0", ok, got, e);
    end
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL stall_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL stall_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  task automatic test_timeout();
    bit ok, got; logic e; int cyc;
    int p0 = stop_cnt, g0 = got_wr;
    hang_mode = 1'b1;
    send_cmd(7'h2A, 4'd1, ok);
    exp_q.delete();  // a hung master never reaches the byte phase
    wait_done(3*TO, got, e, cyc);
    checks++;
    if (!got || e !== 1'b1) begin
      errors++; $display("FAIL timeout_err: done=%b err=%b required 1 1", got, e);
    end
    checks++;
    if (cyc < 2*TO || cyc > 2*TO + 20) begin
      errors++; $display("FAIL timeout_latency: cycles=%0d required %0d..%0d", cyc, 2*TO, 2*TO + 20);
    end
    checks++;
    if (stop_cnt - p0 !== 1 || got_wr - g0 !== 0) begin
      errors++; $display("FAIL timeout_pulses: stop=%0d load=%0d required 1 0",
                         stop_cnt - p0, got_wr - g0);
    end
    hang_mode = 1'b0;
    repeat (3) @(negedge clk);
    got_rd = got_wr;
  endtask

  task automatic test_busy_ignore();
    bit ok, got; logic e; int cyc;
    int s0 = start_cnt;
    feed_mem[0] = 8'h11;
    send_cmd(7'h44, 4'd1, ok);
    exp_q.push_back(8'h11);
    fork
      feed(1, -1, 0);
      wait_done(3000, got, e, cyc);
      begin
        repeat (30) @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 7'h7F; cmd_len = 4'd3;
        repeat (3) begin
          checks++;
          if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL busy_cmd_ready: got=%b required=0", cmd_ready);
          end
          @(negedge clk);
        end
        cmd_valid = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    checks++;
    if (!got || e !== 1'b0 || start_cnt - s0 !== 1 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL busy_dropped: done=%b err=%b starts=%0d state=%0d required 1 0 1 %0d",
                         got, e, start_cnt - s0, dbg_state, S_IDLE);
    end
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL busy_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL busy_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  task automatic test_reset_mid();
    bit ok, got, reached; logic e; int cyc;
    int g0 = got_wr;
    feed_mem[0] = 8'h01;
    send_cmd(7'h10, 4'd2, ok);
    exp_q.push_back(8'h01);
    reached = 1'b0;
    fork
      feed(1, -1, 0);
      begin
        for (int k = 0; k < 2000; k++) begin
          if (got_wr - g0 >= 2) begin reached = 1'b1; break; end
          @(negedge clk);
        end
        repeat (20) @(negedge clk);
      end
    join
    checks++;
    if (!reached) begin errors++; $display("FAIL rmid_reach_byte2: reached=0 required=1"); end
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl: rdy/busy/done/err/wrr=%b%b%b%b%b required=10000",
                         cmd_ready, busy, done, err, wr_ready);
    end
    checks++;
    if (m_start !== 1'b0 || m_stop !== 1'b0 || m_i2c_en !== 1'b0 || m_tx_data !== 8'hFF) begin
      errors++; $display("FAIL rmid_master: start/stop/en=%b%b%b tx=%h required 000 ff",
                         m_start, m_stop, m_i2c_en, m_tx_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL rmid_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL rmid_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
    send_cmd(7'h33, 4'd0, ok);
    wait_done(2000, got, e, cyc);
    checks++;
    if (!ok || !got || e !== 1'b0) begin
      errors++; $display("FAIL rmid_after: accept=%b done=%b err=%b required 1 1 0", ok, got, e);
    end
    checks++;
    if (got_wr - got_rd !== 1 || got_mem[got_rd[7:0]] !== 8'h66) begin
      errors++; $display("FAIL rmid_after_byte: count=%0d byte=%h required 1 66",
                         got_wr - got_rd, got_mem[got_rd[7:0]]);
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  task automatic test_back_to_back();
    bit ok, got; logic e; int cyc;
    logic [6:0] a; logic [LW-1:0] l;
    int w0 = wrr_cnt, nbytes = 0;
    for (int t = 0; t < 3; t++) begin
      a = 7'($urandom_range(0, 127));
      l = LW'($urandom_range(0, 3));
      for (int i = 0; i < int'(l); i++) feed_mem[i] = 8'($urandom_range(0, 255));
      send_cmd(a, l, ok);
      for (int i = 0; i < int'(l); i++) exp_q.push_back(feed_mem[i]);
      nbytes += int'(l);
      fork
        feed(int'(l), -1, 0);
        wait_done(3000, got, e, cyc);
      join
      checks++;
      if (!ok || !got || e !== 1'b0) begin
        errors++; $display("FAIL b2b_done[%0d]: accept=%b done=%b err=%b required 1 1 0", t, ok, got, e);
      end
    end
    checks++;
    if (wrr_cnt - w0 !== nbytes) begin
      errors++; $display("FAIL b2b_wrr: got=%0d required=%0d", wrr_cnt - w0, nbytes);
    end
    checks++;
    if (got_wr - got_rd !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got=%0d required=%0d", got_wr - got_rd, exp_q.size());
    end
    while (got_rd != got_wr && exp_q.size() > 0) begin
      exp_b = exp_q.pop_front(); checks++;
      if (got_mem[got_rd[7:0]] !== exp_b) begin
        errors++; $display("FAIL b2b_byte: got=%h required=%h", got_mem[got_rd[7:0]], exp_b);
      end
      got_rd++;
    end
    exp_q.delete(); got_rd = got_wr;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_addr_only();
    test_multi_byte();
    test_stall();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
